// File: rtl/btn_evt_pkg.sv
// Shared event codes and FSM state encoding for the button event controller.
package btn_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/btn_evt_slot.sv
// One-deep valid/ready event slot. A RELEASE arriving at a stalled full slot
// overwrites it so the consumer always sees the final button state.
module btn_evt_slot
    import btn_evt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] load_code,
    input  logic       ready,
    input  logic       drop_clr,
    output logic       valid,
    output logic [1:0] code,
    output logic       drop
);

    logic accept_ok;

    assign accept_ok = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            code  <= EVT_PRESS;
            drop  <= 1'b0;
        end else begin
            // A loss in the same cycle as drop_clr wins.
            if (drop_clr)
                drop <= 1'b0;
            if (load) begin
                if (accept_ok) begin
                    valid <= 1'b1;
                    code  <= load_code;
                end else begin
                    drop <= 1'b1;
                    if (load_code == EVT_RELEASE)
                        code <= load_code;
                end
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events,
// delivered through a one-deep valid/ready slot.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int          CNT_W      = $clog2((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       held,
    output logic       evt_drop,
    input  logic       drop_clr
);

    logic             btn_q;
    logic             rise;
    logic             fall;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             long_hit;
    logic             rep_hit;
    logic             evt_ld;
    logic [1:0]       evt_nxt;

    assign rise     = btn_i & ~btn_q;
    assign fall     = ~btn_i & btn_q;
    assign long_hit = (cnt == CNT_W'(LONG_CYC - 1));
    assign rep_hit  = (cnt == CNT_W'(REPEAT_CYC - 1));

    // Event detection is combinational so the slot shows it one cycle later.
    always_comb begin
        evt_ld  = 1'b0;
        evt_nxt = EVT_PRESS;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    evt_ld  = 1'b1;
                    evt_nxt = EVT_PRESS;
                end
            end
            S_HOLD: begin
                if (fall) begin
                    evt_ld  = 1'b1;
                    evt_nxt = EVT_RELEASE;
                end else if (long_hit) begin
                    evt_ld  = 1'b1;
                    evt_nxt = EVT_LONG;
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    evt_ld  = 1'b1;
                    evt_nxt = EVT_RELEASE;
                end else if (rep_hit) begin
                    evt_ld  = 1'b1;
                    evt_nxt = EVT_REPEAT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
            state <= S_IDLE;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            btn_q <= btn_i;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        held  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (fall) begin
                        state <= S_IDLE;
                        held  <= 1'b0;
                    end else if (long_hit) begin
                        state <= S_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (fall) begin
                        state <= S_IDLE;
                        held  <= 1'b0;
                    end else if (rep_hit) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

    btn_evt_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (evt_ld),
        .load_code (evt_nxt),
        .ready     (evt_ready),
        .drop_clr  (drop_clr),
        .valid     (evt_valid),
        .code      (evt_code),
        .drop      (evt_drop)
    );

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a
// timeline-based reference model of the button events and output slot.
module tb_button_event_ctrl;

    localparam int L = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_i;
    logic       evt_ready;
    logic       drop_clr;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       held;
    logic       evt_drop;

    always #5 clk = ~clk;

    button_event_ctrl #(.LONG_CYC(L), .REPEAT_CYC(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_i),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .held      (held),
        .evt_drop  (evt_drop),
        .drop_clr  (drop_clr)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Reference: button level history expressed as the time of the last rise.
    logic       m_btn_q = 1'b0;
    logic       m_valid = 1'b0;
    logic [1:0] m_code  = 2'd0;
    logic       m_drop  = 1'b0;
    int         t_rise  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic model_step();
        bit         ev;
        logic [1:0] c;
        int         age;
        if (rst) begin
            m_btn_q = 1'b0;
            m_valid = 1'b0;
            m_code  = 2'd0;
            m_drop  = 1'b0;
            return;
        end
        ev = 1'b0;
        c  = 2'd0;
        if (btn_i && !m_btn_q) begin
            ev = 1'b1; c = 2'd0; t_rise = cyc;
        end else if (!btn_i && m_btn_q) begin
            ev = 1'b1; c = 2'd1;
        end else if (btn_i) begin
            age = cyc - t_rise;
            if (age == L) begin
                ev = 1'b1; c = 2'd2;
            end else if (age > L && (age - L) % R == 0) begin
                ev = 1'b1; c = 2'd3;
            end
        end
        if (drop_clr)
            m_drop = 1'b0;
        if (ev) begin
            if (!m_valid || evt_ready) begin
                m_valid = 1'b1;
                m_code  = c;
            end else begin
                m_drop = 1'b1;
                if (c == 2'd1)
                    m_code = c;
            end
        end else if (evt_ready) begin
            m_valid = 1'b0;
        end
        m_btn_q = btn_i;
    endtask

    task automatic step(input logic b, input logic r, input logic c, input logic rs = 1'b0);
        btn_i     = b;
        evt_ready = r;
        drop_clr  = c;
        rst       = rs;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", {7'd0, evt_valid}, {7'd0, m_valid});
        if (m_valid)
            chk("code", {6'd0, evt_code}, {6'd0, m_code});
        chk("held", {7'd0, held}, {7'd0, m_btn_q});
        chk("drop", {7'd0, evt_drop}, {7'd0, m_drop});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_state", {3'd0, evt_valid, evt_code, held, evt_drop}, 8'd0);
        idle(2);

        // 1: short press
        for (int i = 0; i < 8; i++) begin
            step(i < 3, 1'b1, 1'b0);
            if (i == 0) chk("t1_press",   {evt_valid, evt_code}, 8'b100);
            if (i == 3) chk("t1_release", {evt_valid, evt_code}, 8'b101);
        end
        idle(2);

        // 2: long hold with repeats, fall coincides with repeat threshold
        for (int i = 0; i < 26; i++) begin
            step(i < 20, 1'b1, 1'b0);
            if (i == 8)  chk("t2_long",    {evt_valid, evt_code}, 8'b110);
            if (i == 12) chk("t2_rep1",    {evt_valid, evt_code}, 8'b111);
            if (i == 16) chk("t2_rep2",    {evt_valid, evt_code}, 8'b111);
            if (i == 19) chk("t2_quiet",   {7'd0, evt_valid}, 8'd0);
            if (i == 20) chk("t2_release", {evt_valid, evt_code}, 8'b101);
        end
        idle(2);

        // 3: stalled consumer, LONG dropped, RELEASE overwrites
        for (int i = 0; i < 20; i++) begin
            step(i < 12, i >= 17, i == 15);
            if (i == 8)  chk("t3_long_drop", {evt_valid, evt_code, evt_drop}, 8'b1001);
            if (i == 12) chk("t3_overwrite", {evt_valid, evt_code, evt_drop}, 8'b1011);
            if (i == 15) chk("t3_clr",       {7'd0, evt_drop}, 8'd0);
        end
        idle(2);

        // 4: accept and load in the same cycle
        for (int i = 0; i < 14; i++) begin
            step(i < 10, i >= 8, 1'b0);
            if (i == 7) chk("t4_press_held", {evt_valid, evt_code, evt_drop}, 8'b1000);
            if (i == 8) chk("t4_long_swap",  {evt_valid, evt_code, evt_drop}, 8'b1100);
        end
        idle(2);

        // 5: reset mid-hold
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, i == 5);
            if (i == 5) chk("t5_reset",  {3'd0, evt_valid, evt_code, held, evt_drop}, 8'd0);
            if (i == 6) chk("t5_refire", {evt_valid, evt_code}, 8'b100);
        end
        idle(3);

        // 6: back-to-back rise/fall/rise
        for (int i = 0; i < 5; i++) begin
            step(i == 0 || i == 2, 1'b1, 1'b0);
            if (i == 0) chk("t6_press1", {evt_valid, evt_code}, 8'b100);
            if (i == 1) chk("t6_rel",    {evt_valid, evt_code}, 8'b101);
            if (i == 2) chk("t6_press2", {evt_valid, evt_code}, 8'b100);
        end
        idle(2);

        // random traffic
        begin
            logic b = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 14) == 0) b = ~b;
                step(b, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 249) == 0);
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
